// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, line levels and default baud constants.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam logic StartLevel = 1'b0;
  localparam logic IdleLevel  = 1'b1;

  localparam int unsigned CLK_F = 25_000_000;
  localparam int unsigned BAUD  = 9600;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     any
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [IdW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    // Offset N_REQ lands back on last itself, so a lone requester can win twice in a row.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IdW'((32'(last) + k) % N_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1-style UART transmit line among N_REQ byte producers, round-robin,
// with bit boundaries paced by an external baud tick.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);
  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned BitW = $clog2(DATA_W);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] sel_data;
  logic [BitW-1:0]   bit_idx_q;
  logic              stop_cnt_q;
  logic [IdW-1:0]    last_q;
  logic [IdW-1:0]    arb_id;
  logic [N_REQ-1:0]  arb_gnt;
  logic              arb_any;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .gnt   (arb_gnt),
    .gnt_id(arb_id),
    .any   (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_id == IdW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign shift_nxt = shift_q >> 1;

  // Gated by reset so no accept strobe leaks out while the FSM is held.
  assign req_ready = (state_q == StIdle && !reset) ? arb_gnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tx         <= IdleLevel;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_q     <= IdW'(N_REQ - 1);
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            shift_q  <= sel_data;
            grant_id <= arb_id;
            last_q   <= arb_id;
            busy     <= 1'b1;
            state_q  <= StArm;
          end
        end
        StArm: begin
          if (tick) begin
            tx      <= StartLevel;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            tx        <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (bit_idx_q == BitW'(DATA_W - 1)) begin
              tx         <= IdleLevel;
              stop_cnt_q <= 1'b0;
              state_q    <= StStop;
            end else begin
              shift_q   <= shift_nxt;
              tx        <= shift_nxt[0];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected frames, monitors decode tx.
module tb_uart_tx_scheduler;
  localparam int PERIOD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] req_valid;
  logic [31:0] req_data;
  logic [3:0] req_ready;
  logic       tx;
  logic       busy;
  logic [1:0] grant_id;

  logic [1:0]  req_valid2;
  logic [13:0] req_data2;
  logic [1:0]  req_ready2;
  logic        tx2;
  logic        busy2;
  logic [0:0]  grant_id2;

  uart_tx_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_scheduler #(.N_REQ(2), .DATA_W(7), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .tx(tx2), .busy(busy2), .grant_id(grant_id2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Producer-side queues, expected frames and expected dut2 line bits.
  logic [7:0] pending [4][$];
  int         exp_id [$];
  logic [7:0] exp_data [$];
  logic       exp2 [$];
  int         ready_cycles [4];
  bit         align = 1'b0;
  bit         bb_check = 1'b0;

  // Baud tick: one cycle every PERIOD, re-phased on request.
  int tick_cnt;
  initial begin
    tick = 1'b0;
    tick_cnt = 0;
    forever begin
      @(negedge clk);
      if (align) begin
        tick = 1'b1;
        tick_cnt = 0;
        align = 1'b0;
      end else begin
        tick = (tick_cnt == PERIOD - 1);
        tick_cnt = tick ? 0 : tick_cnt + 1;
      end
    end
  end

  // Producers: hold valid/data until accepted, then move to the next queued byte.
  logic [3:0] acc;
  initial begin
    req_valid = '0;
    req_data  = '0;
    foreach (ready_cycles[i]) ready_cycles[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = (pending[i].size() != 0);
        if (req_valid[i]) req_data[i*8 +: 8] = pending[i][0];
      end
      #1;
      acc = req_valid & req_ready;
      for (int i = 0; i < 4; i++) if (req_ready[i]) ready_cycles[i]++;
      if (req_ready != 4'b0) begin
        check("ready_onehot", int'($onehot(req_ready)), 1);
        check("ready_only_idle", int'(busy), 0);
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && pending[i].size() != 0) void'(pending[i].pop_front());
      end
    end
  end

  // Frame monitor for dut: decodes tx at tick edges and scores against the queue.
  int         cyc = 0;
  int         close_cyc = 0;
  bit         have_close = 1'b0;
  int         m_state = 0;
  int         m_cnt = 0;
  int         m_id = 0;
  logic [7:0] m_data = '0;
  bit         m_stable = 1'b1;
  bit         m_stop_ok = 1'b1;
  logic       m_prev = 1'b1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        m_state = 0;
        have_close = 1'b0;
      end else if (tick) begin
        case (m_state)
          0: if (tx == 1'b0) begin
            if (bb_check && have_close) check("rr_gap", cyc - close_cyc, PERIOD);
            m_state = 1;
            m_cnt = 0;
            m_id = int'(grant_id);
            m_stable = 1'b1;
            m_stop_ok = 1'b1;
          end
          1: begin
            m_data[m_cnt] = tx;
            m_cnt++;
            if (m_cnt == 8) begin
              m_state = 2;
              m_cnt = 0;
            end
          end
          default: begin
            m_stop_ok &= tx;
            if (m_cnt < 1) begin
              m_cnt++;
            end else begin
              check("busy_fall", int'(busy), 0);
              check("stop_high", int'(m_stop_ok), 1);
              check("bit_stable", int'(m_stable), 1);
              if (exp_id.size() == 0) begin
                check("unexpected_frame", m_id, -1);
              end else begin
                check("frame_id", m_id, exp_id.pop_front());
                check("frame_data", int'(m_data), int'(exp_data.pop_front()));
              end
              m_state = 0;
              close_cyc = cyc;
              have_close = 1'b1;
            end
          end
        endcase
      end else if (m_state != 0 && tx != m_prev) begin
        m_stable = 1'b0;
      end
      m_prev = tx;
    end
  end

  // Line monitor for dut2 (7 data bits, 2 stop bits).
  int m2_state = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m2_state = 0;
      end else if (tick) begin
        if (m2_state == 2) begin
          check("dut2_busy_fall", int'(busy2), 0);
          m2_state = 0;
        end else if ((m2_state == 1 || tx2 == 1'b0) && exp2.size() != 0) begin
          m2_state = 1;
          check("dut2_bit", int'(tx2), int'(exp2.pop_front()));
          if (exp2.size() == 0) m2_state = 2;
        end
      end
    end
  end

  task automatic give(input int i, input logic [7:0] d);
    pending[i].push_back(d);
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d);
    exp_id.push_back(id);
    exp_data.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int busy_left;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #2;
      busy_left = 0;
      for (int j = 0; j < 4; j++) busy_left += pending[j].size();
      if (exp_id.size() == 0 && !busy && busy_left == 0) break;
    end
    check(name, exp_id.size(), 0);
  endtask

  task automatic wait_busy(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #2;
      if (busy) break;
    end
    check("wait_busy", int'(busy), 1);
  endtask

  logic [9:0] frame2;
  bit         got2;

  initial begin
    reset = 1'b1;
    req_valid2 = '0;
    req_data2  = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_ready", int'(req_ready), 0);
    reset = 1'b0;

    // Round-robin from reset: 0,1,2,3,0 back-to-back.
    bb_check = 1'b1;
    give(0, 8'h11); give(1, 8'h22); give(2, 8'h33); give(3, 8'h44); give(0, 8'h55);
    expect_frame(0, 8'h11); expect_frame(1, 8'h22); expect_frame(2, 8'h33);
    expect_frame(3, 8'h44); expect_frame(0, 8'h55);
    wait_drain("rr_drain", 400);
    bb_check = 1'b0;

    // Single byte from requester 2.
    foreach (ready_cycles[i]) ready_cycles[i] = 0;
    give(2, 8'hA5);
    expect_frame(2, 8'hA5);
    wait_drain("single_drain", 100);
    check("single_ready_pulse", ready_cycles[2], 1);
    check("single_grant_id", int'(grant_id), 2);

    // Withdrawal: requester 1 drops out during a frame, 3 is served next.
    foreach (ready_cycles[i]) ready_cycles[i] = 0;
    give(0, 8'h3C);
    expect_frame(0, 8'h3C);
    wait_busy(20);
    give(1, 8'h99);
    give(3, 8'h66);
    expect_frame(3, 8'h66);
    repeat (10) @(posedge clk);
    #2;
    pending[1].delete();
    wait_drain("withdraw_drain", 200);
    check("withdraw_no_ready1", ready_cycles[1], 0);

    // Tick in the acceptance cycle must not launch the start bit.
    @(posedge clk);
    #2;
    align = 1'b1;
    give(1, 8'hC3);
    expect_frame(1, 8'hC3);
    @(posedge clk);
    #1;
    check("coinc_busy", int'(busy), 1);
    check("coinc_tx_accept", int'(tx), 1);
    repeat (3) @(posedge clk);
    #1;
    check("coinc_tx_pre_start", int'(tx), 1);
    @(posedge clk);
    #1;
    check("coinc_tx_start", int'(tx), 0);
    wait_drain("coinc_drain", 100);

    // Reset mid-DATA: frame aborted, requester 0 wins after release.
    give(1, 8'h00);
    wait_busy(20);
    give(0, 8'h0F);
    give(2, 8'h5A);
    expect_frame(0, 8'h0F);
    expect_frame(2, 8'h5A);
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_tx", int'(tx), 0);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(req_ready), 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    wait_drain("midrst_drain", 200);

    // dut2: 0x41 on 7 data bits, 2 stop bits -> 0,1,0,0,0,0,0,1,1,1.
    frame2 = 10'b1110000010;
    for (int i = 0; i < 10; i++) exp2.push_back(frame2[i]);
    @(posedge clk);
    #2;
    req_data2  = {7'h00, 7'h41};
    req_valid2 = 2'b01;
    got2 = 1'b0;
    for (int i = 0; i < 20 && !got2; i++) begin
      @(negedge clk);
      #1;
      got2 = req_ready2[0];
    end
    check("dut2_accept", int'(got2), 1);
    @(posedge clk);
    #2;
    req_valid2 = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (exp2.size() == 0 && !busy2) break;
    end
    repeat (3) @(posedge clk);
    check("dut2_drain", exp2.size(), 0);
    check("dut2_idle", int'(busy2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
